// File: rtl/scan_target_router.sv
// Routes scan read/write requests to the SRAM port or the control/status register port.
// It tracks one outstanding request, times out a stalled target and counts error completions.
module scan_target_router #(
  parameter int                 ADDR_W   = 15,
  parameter int                 DATA_W   = 32,
  parameter int                 SRAM_AW  = 11,
  parameter int                 NUM_SEG  = 4,
  parameter int                 TIMEOUT  = 16,
  parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEAD_BEEF,
  localparam int                SEG_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_ren,
  input  logic                scan_wen,
  input  logic [ADDR_W-1:0]   scan_addr,
  input  logic [DATA_W-1:0]   scan_wdata,
  output logic [DATA_W-1:0]   scan_rdata,
  output logic                scan_ready,
  output logic                scan_err,
  output logic                scan_busy,
  output logic                sram_ren,
  output logic                sram_wen,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  input  logic                sram_ready,
  output logic                reg_ren,
  output logic                reg_wen,
  output logic [DATA_W-1:0]   reg_wdata,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ready,
  output logic [SEG_W-1:0]    seg_id,
  output logic                id_sel,
  output logic [7:0]          err_count
);

  if (ADDR_W < SRAM_AW + SEG_W + 2) begin : g_bad_addr_w
    $error("scan_target_router: ADDR_W too small for SRAM_AW + SEG_W + 2");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("scan_target_router: TIMEOUT must be within 2..255");
  end

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic                 is_reg_reg;
  logic                 is_write_reg;
  logic [SRAM_AW-1:0]   word_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [SEG_W-1:0]     seg_reg;
  logic                 id_sel_reg;
  logic [7:0]           wdog_reg;
  logic [DATA_W-1:0]    rdata_reg;
  logic                 err_reg;
  logic [7:0]           err_count_reg;

  logic                 latch_req;
  logic                 resp_load;
  logic                 resp_err;
  logic [DATA_W-1:0]    resp_data;
  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;

  // Only the selected target can complete a transaction.
  assign sel_ready = is_reg_reg ? reg_ready : sram_ready;
  assign sel_rdata = is_reg_reg ? reg_rdata : sram_rdata;

  always_comb begin
    state_next = state_reg;
    latch_req  = 1'b0;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_reg)
      IDLE: begin
        if (scan_ren ^ scan_wen) begin
          latch_req  = 1'b1;
          state_next = ISSUE;
        end else if (scan_ren & scan_wen) begin
          resp_load  = 1'b1;
          resp_err   = 1'b1;
          resp_data  = ERR_DATA;
          state_next = RESP;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A ready in the final watchdog cycle still completes cleanly.
        if (sel_ready) begin
          resp_load  = 1'b1;
          resp_data  = is_write_reg ? '0 : sel_rdata;
          state_next = RESP;
        end else if (wdog_reg == WDOG_LAST) begin
          resp_load  = 1'b1;
          resp_err   = 1'b1;
          resp_data  = ERR_DATA;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      is_reg_reg    <= 1'b0;
      is_write_reg  <= 1'b0;
      word_reg      <= '0;
      wdata_reg     <= '0;
      seg_reg       <= '0;
      id_sel_reg    <= 1'b0;
      wdog_reg      <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_req) begin
        is_reg_reg   <= scan_addr[ADDR_W-1];
        is_write_reg <= scan_wen;
        word_reg     <= scan_addr[SRAM_AW-1:0];
        wdata_reg    <= scan_wdata;
        seg_reg      <= scan_addr[SRAM_AW +: SEG_W];
        id_sel_reg   <= scan_addr[ADDR_W-2];
      end
      wdog_reg <= (state_reg == WAIT) ? wdog_reg + 8'd1 : 8'd0;
      if (resp_load) begin
        rdata_reg <= resp_data;
        err_reg   <= resp_err;
      end
      if (state_reg == RESP && err_reg && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign scan_ready = (state_reg == RESP);
  assign scan_err   = (state_reg == RESP) & err_reg;
  assign scan_busy  = (state_reg != IDLE);
  assign scan_rdata = rdata_reg;

  assign sram_ren   = (state_reg == ISSUE) & ~is_reg_reg & ~is_write_reg;
  assign sram_wen   = (state_reg == ISSUE) & ~is_reg_reg &  is_write_reg;
  assign reg_ren    = (state_reg == ISSUE) &  is_reg_reg & ~is_write_reg;
  assign reg_wen    = (state_reg == ISSUE) &  is_reg_reg &  is_write_reg;

  assign sram_addr  = is_reg_reg ? '0 : word_reg;
  assign sram_wdata = is_reg_reg ? '0 : wdata_reg;
  assign reg_wdata  = is_reg_reg ? wdata_reg : '0;

  assign seg_id     = seg_reg;
  assign id_sel     = id_sel_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_scan_target_router.sv
// Self-checking bench for scan_target_router: directed vector table, reset/saturation
// sequences and randomized transactions checked against a transaction-level model.
module tb_scan_target_router;

  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_ren, scan_wen;
  logic [14:0] scan_addr;
  logic [31:0] scan_wdata, scan_rdata;
  logic        scan_ready, scan_err, scan_busy;
  logic        sram_ren, sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_ready;
  logic        reg_ren, reg_wen;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_ready;
  logic [1:0]  seg_id;
  logic        id_sel;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  scan_target_router #(
    .ADDR_W(15), .DATA_W(32), .SRAM_AW(11), .NUM_SEG(4),
    .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr),
    .scan_wdata(scan_wdata), .scan_rdata(scan_rdata), .scan_ready(scan_ready),
    .scan_err(scan_err), .scan_busy(scan_busy),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .reg_ren(reg_ren), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .seg_id(seg_id), .id_sel(id_sel), .err_count(err_count)
  );

  // kind: 0 read, 1 write, 2 illegal (ren & wen); delay = WAIT cycle index of the ready
  typedef struct {
    int          kind;
    logic [14:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rd;
    bit          poke_busy;
    bit          wrong_ready;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int err_model = 0;
  logic [1:0] last_seg = 2'd0;
  logic       last_id = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: request at cycle 0, completion cycle and response.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit illegal;
    r = v;
    illegal = (v.kind == 2);
    r.exp_err = illegal || (v.delay >= TIMEOUT);
    if (illegal)                r.exp_lat = 1;
    else if (v.delay < TIMEOUT) r.exp_lat = 3 + v.delay;
    else                        r.exp_lat = TIMEOUT + 2;
    if (r.exp_err)              r.exp_rdata = ERR_DATA;
    else if (v.kind == 1)       r.exp_rdata = 32'h0;
    else                        r.exp_rdata = v.rd;
    return r;
  endfunction

  task automatic idle_inputs();
    scan_ren = 1'b0; scan_wen = 1'b0;
    sram_ready = 1'b0; reg_ready = 1'b0;
    sram_rdata = $urandom; reg_rdata = $urandom;
  endtask

  task automatic run_txn(input vec_t v);
    bit illegal, is_reg, wr;
    int limit, first_strobe, n_ready, ready_cyc, err_out;
    int n_sr, n_sw, n_rr, n_rw;
    logic rerr;
    logic [31:0] rdat;
    illegal = (v.kind == 2);
    is_reg = v.addr[14];
    wr = (v.kind == 1);
    limit = v.exp_lat + 4;
    first_strobe = -1; n_ready = 0; ready_cyc = -1; err_out = 0;
    n_sr = 0; n_sw = 0; n_rr = 0; n_rw = 0;
    rerr = 1'b0; rdat = 32'h0;
    idle_inputs();
    scan_addr = v.addr;
    scan_wdata = v.wdata;
    scan_ren = (v.kind == 0 || v.kind == 2);
    scan_wen = (v.kind == 1 || v.kind == 2);
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (!illegal && cyc == 2 + v.delay) begin
        if (is_reg) begin reg_ready = 1'b1; reg_rdata = v.rd; end
        else begin sram_ready = 1'b1; sram_rdata = v.rd; end
      end
      if (!illegal && cyc == v.exp_lat + 1) begin
        if (is_reg) reg_ready = 1'b1; else sram_ready = 1'b1;
      end
      if (v.wrong_ready && cyc == 2) begin
        if (is_reg) begin sram_ready = 1'b1; sram_rdata = 32'hBAD0_BAD0; end
        else begin reg_ready = 1'b1; reg_rdata = 32'hBAD0_BAD0; end
      end
      if (v.poke_busy && cyc == 2) begin
        scan_ren = 1'b1;
        scan_addr = ~v.addr;
      end
      if (sram_ren) n_sr++;
      if (sram_wen) n_sw++;
      if (reg_ren)  n_rr++;
      if (reg_wen)  n_rw++;
      if ((sram_ren | sram_wen | reg_ren | reg_wen) && first_strobe < 0) first_strobe = cyc;
      if (scan_ready) begin
        n_ready++; ready_cyc = cyc; rerr = scan_err; rdat = scan_rdata;
      end else if (scan_err) begin
        err_out++;
      end
      if (cyc == 1) begin
        chk("busy_in_flight", 32'(scan_busy), 32'd1);
        if (!illegal) begin
          chk("sram_addr", 32'(sram_addr), is_reg ? 32'h0 : 32'(v.addr[10:0]));
          chk("seg_id", 32'(seg_id), 32'(v.addr[12:11]));
          chk("id_sel", 32'(id_sel), 32'(v.addr[13]));
          if (wr) begin
            chk("sram_wdata", sram_wdata, is_reg ? 32'h0 : v.wdata);
            chk("reg_wdata", reg_wdata, is_reg ? v.wdata : 32'h0);
          end
        end
      end
    end
    if (!illegal) begin
      last_seg = v.addr[12:11];
      last_id = v.addr[13];
    end
    if (v.exp_err) err_model = (err_model >= 255) ? 255 : err_model + 1;
    chk("ready_count", 32'(n_ready), 32'd1);
    chk("ready_cycle", 32'(ready_cyc), 32'(v.exp_lat));
    chk("resp_err", 32'(rerr), 32'(v.exp_err));
    chk("resp_rdata", rdat, v.exp_rdata);
    chk("strobe_counts", {8'(n_sr), 8'(n_sw), 8'(n_rr), 8'(n_rw)},
        {7'd0, !illegal && !is_reg && !wr, 7'd0, !illegal && !is_reg && wr,
         7'd0, !illegal && is_reg && !wr, 7'd0, !illegal && is_reg && wr});
    chk("strobe_cycle", 32'(first_strobe), illegal ? 32'hFFFF_FFFF : 32'd1);
    chk("err_outside_resp", 32'(err_out), 32'd0);
    chk("busy_after", 32'(scan_busy), 32'd0);
    chk("rdata_held", scan_rdata, v.exp_rdata);
    chk("seg_held", {29'd0, last_id, last_seg}, {29'd0, id_sel, seg_id});
    chk("err_count", 32'(err_count), 32'(err_model));
    $display("txn kind=%0d addr=%h delay=%0d lat=%0d err=%0b rdata=%h err_count=%0d",
             v.kind, v.addr, v.delay, ready_cyc, rerr, rdat, err_count);
  endtask

  vec_t table_v[9];
  vec_t rv;
  int   n_rst_ready;

  initial begin
    rst_n = 1'b0;
    scan_addr = '0; scan_wdata = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ctrl", {24'd0, scan_ready, scan_err, scan_busy, sram_ren, sram_wen, reg_ren, reg_wen, id_sel}, 32'd0);
    chk("reset_data", scan_rdata | sram_wdata | reg_wdata | 32'(sram_addr) | 32'(seg_id) | 32'(err_count), 32'd0);

    //               kind addr      wdata          delay rd            busy wrong lat err rdata
    table_v[0] = '{0, 15'h0123, 32'h0,         0,  32'hA5A5_0001, 0, 0, 3,  0, 32'hA5A5_0001};
    table_v[1] = '{1, 15'h4000, 32'h1234_5678, 0,  32'hFFFF_FFFF, 0, 0, 3,  0, 32'h0};
    table_v[2] = '{0, 15'h3FFF, 32'h0,         2,  32'h0BAD_F00D, 0, 0, 5,  0, 32'h0BAD_F00D};
    table_v[3] = '{0, 15'h0010, 32'h0,         99, 32'h1111_1111, 0, 1, 18, 1, ERR_DATA};
    table_v[4] = '{2, 15'h0000, 32'h0,         0,  32'h0,         0, 0, 1,  1, ERR_DATA};
    table_v[5] = '{0, 15'h0555, 32'h0,         3,  32'h1111_2222, 1, 0, 6,  0, 32'h1111_2222};
    table_v[6] = '{0, 15'h4ABC, 32'h0,         15, 32'h7777_8888, 0, 1, 18, 0, 32'h7777_8888};
    table_v[7] = '{1, 15'h2222, 32'hCAFE_0000, 16, 32'h0,         0, 0, 18, 1, ERR_DATA};
    table_v[8] = '{1, 15'h1800, 32'h0F0F_0F0F, 1,  32'h5555_5555, 1, 1, 4,  0, 32'h0};
    for (int i = 0; i < 9; i++) run_txn(table_v[i]);

    // Reset during WAIT aborts the transaction silently.
    idle_inputs();
    scan_addr = 15'h0042; scan_ren = 1'b1;
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    err_model = 0; last_seg = 2'd0; last_id = 1'b0;
    chk("midreset_ctrl", {24'd0, scan_ready, scan_err, scan_busy, sram_ren, sram_wen, reg_ren, reg_wen, id_sel}, 32'd0);
    chk("midreset_data", scan_rdata | sram_wdata | reg_wdata | 32'(sram_addr) | 32'(seg_id) | 32'(err_count), 32'd0);
    n_rst_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (scan_ready) n_rst_ready++;
    end
    chk("midreset_no_ready", 32'(n_rst_ready), 32'd0);
    $display("txn reset mid-WAIT err_count=%0d", err_count);
    run_txn(model('{0, 15'h0042, 32'h0, 0, 32'h600D_0042, 0, 0, 0, 0, 32'h0}));

    for (int i = 0; i < 40; i++) begin
      rv.kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      rv.addr = 15'($urandom);
      rv.wdata = $urandom;
      rv.delay = int'($urandom_range(0, 20));
      rv.rd = $urandom;
      rv.poke_busy = (rv.kind != 2) && ($urandom_range(0, 3) == 0);
      rv.wrong_ready = ($urandom_range(0, 2) == 0);
      run_txn(model(rv));
    end

    // Drive enough illegal requests to saturate the error counter.
    for (int i = 0; i < 260; i++) begin
      idle_inputs();
      scan_ren = 1'b1; scan_wen = 1'b1;
      @(posedge clk); #1 idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      err_model = (err_model >= 255) ? 255 : err_model + 1;
    end
    chk("err_count_saturate", 32'(err_count), 32'(err_model));
    $display("txn 260 illegal requests err_count=%0d", err_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
